// File: rtl/scan_chain_sequencer.sv
// scan_chain_sequencer
//   On-chip scan test controller for a single internal scan chain. A test
//   shifts a CHAIN_LEN-bit stimulus in (MSB first), applies one functional
//   capture cycle, then shifts the response out and compares it with the
//   expected vector.
//
// Ports
//   Clk         in   rising-edge clock, shared with the scan chain
//   ClrN        in   asynchronous active-low reset
//   start       in   request one test (sampled only while idle)
//   pattern_in  in   stimulus, bit i lands in chain position i (0 = nearest tdi)
//   expect_in   in   expected capture, bit i compared with position i
//   tdo         in   serial out of the chain (position CHAIN_LEN-1)
//   tms         out  scan enable to all chain flops (1 = shift, 0 = functional)
//   tdi         out  serial in to chain position 0
//   busy        out  test in progress
//   done        out  one-cycle pulse when the result is valid
//   pass        out  captured == expect_in, held until the next accepted start
//   captured    out  raw response, bit i = captured value of position i
module scan_chain_sequencer #(
  parameter int CHAIN_LEN = 3,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 Clk,
  input  logic                 ClrN,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expect_in,
  input  logic                 tdo,
  output logic                 tms,
  output logic                 tdi,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] captured
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_CAPTURE   = 3'd2,
    S_SHIFT_OUT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [CHAIN_LEN-1:0] r_pat, w_pat_next;
  logic [CHAIN_LEN-1:0] r_exp, w_exp_next;
  logic [CHAIN_LEN-1:0] r_captured, w_cap_next;
  logic                 r_pass, w_pass_next;
  logic                 r_tms, w_tms_next;
  logic                 r_tdi, w_tdi_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;

  // Response register with the current tdo sample appended at bit 0. The
  // first sample (position CHAIN_LEN-1) therefore ends up in the MSB after
  // CHAIN_LEN samples.
  logic [CHAIN_LEN-1:0] w_cap_shift;

  generate
    if (CHAIN_LEN == 1) begin : g_cap_single
      assign w_cap_shift = tdo;
    end else begin : g_cap_multi
      assign w_cap_shift = {r_captured[CHAIN_LEN-2:0], tdo};
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pat_next   = r_pat;
    w_exp_next   = r_exp;
    w_cap_next   = r_captured;
    w_pass_next  = r_pass;
    w_tms_next   = 1'b0;
    w_tdi_next   = 1'b0;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_SHIFT_IN;
          w_cnt_next   = '0;
          // The MSB goes out immediately; the rest is kept left-aligned so
          // the next bit to send is always r_pat[CHAIN_LEN-1].
          w_tdi_next   = pattern_in[CHAIN_LEN-1];
          w_pat_next   = pattern_in << 1;
          w_exp_next   = expect_in;
          w_cap_next   = '0;
          w_pass_next  = 1'b0;
          w_tms_next   = 1'b1;
          w_busy_next  = 1'b1;
        end
      end

      S_SHIFT_IN: begin
        w_busy_next = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_next = S_CAPTURE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next  = r_cnt + CNT_W'(1);
          w_tms_next  = 1'b1;
          w_tdi_next  = r_pat[CHAIN_LEN-1];
          w_pat_next  = r_pat << 1;
        end
      end

      S_CAPTURE: begin
        w_state_next = S_SHIFT_OUT;
        w_cnt_next   = '0;
        w_tms_next   = 1'b1;
        w_busy_next  = 1'b1;
      end

      S_SHIFT_OUT: begin
        w_cap_next = w_cap_shift;
        if (r_cnt == CNT_LAST) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
          // Compare against the fully assembled response, including the
          // bit sampled on this very edge.
          w_pass_next  = (w_cap_shift == r_exp);
        end else begin
          w_cnt_next  = r_cnt + CNT_W'(1);
          w_tms_next  = 1'b1;
          w_busy_next = 1'b1;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pat      <= '0;
      r_exp      <= '0;
      r_captured <= '0;
      r_pass     <= 1'b0;
      r_tms      <= 1'b0;
      r_tdi      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_pat      <= w_pat_next;
      r_exp      <= w_exp_next;
      r_captured <= w_cap_next;
      r_pass     <= w_pass_next;
      r_tms      <= w_tms_next;
      r_tdi      <= w_tdi_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign tms      = r_tms;
  assign tdi      = r_tdi;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign captured = r_captured;

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Bench for scan_chain_sequencer: a 3-flop build and a 1-flop build, each
// driving a behavioural scan chain whose functional D is ~Q of the same flop.
// Expected responses are queued when a start is accepted and checked by an
// independent monitor on the falling clock edge.
module tb_scan_chain_sequencer;

  localparam int MAXC = 2048;

  logic       Clk  = 1'b0;
  logic       ClrN = 1'b1;

  logic       start0 = 1'b0;
  logic [2:0] pat0   = 3'b000;
  logic [2:0] exp0   = 3'b000;
  logic       tdo0;
  logic       tms0, tdi0, busy0, done0, pass0;
  logic [2:0] cap0;

  logic       start1 = 1'b0;
  logic [0:0] pat1   = 1'b0;
  logic [0:0] exp1   = 1'b0;
  logic       tdo1;
  logic       tms1, tdi1, busy1, done1, pass1;
  logic [0:0] cap1;

  scan_chain_sequencer #(.CHAIN_LEN(3)) dut0 (
    .Clk(Clk), .ClrN(ClrN), .start(start0), .pattern_in(pat0), .expect_in(exp0),
    .tdo(tdo0), .tms(tms0), .tdi(tdi0), .busy(busy0), .done(done0),
    .pass(pass0), .captured(cap0)
  );

  scan_chain_sequencer #(.CHAIN_LEN(1)) dut1 (
    .Clk(Clk), .ClrN(ClrN), .start(start1), .pattern_in(pat1), .expect_in(exp1),
    .tdo(tdo1), .tms(tms1), .tdi(tdi1), .busy(busy1), .done(done1),
    .pass(pass1), .captured(cap1)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Scan chain models: shift toward higher positions when tms=1, invert otherwise.
  logic [2:0] q0 = 3'b000;
  logic       q1 = 1'b0;
  always @(posedge Clk) q0 <= tms0 ? {q0[1:0], tdi0} : ~q0;
  always @(posedge Clk) q1 <= tms1 ? tdi1 : ~q1;
  assign tdo0 = q0[2];
  assign tdo1 = q1;

  // Per-cycle expected pin values for each build, filled in on acceptance.
  bit e_tms  [0:1][0:MAXC-1];
  bit e_tdi  [0:1][0:MAXC-1];
  bit e_busy [0:1][0:MAXC-1];
  bit e_done [0:1][0:MAXC-1];
  bit e_clr  [0:1][0:MAXC-1];
  int free_at  [0:1];
  int last_acc [0:1];

  typedef struct {
    logic [2:0] cap;
    logic       pass;
    int         cyc;
  } sb_t;
  sb_t sb0[$];
  sb_t sb1[$];

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic put(int d, int c, bit t, bit i, bit b, bit dn, bit cl);
    if (c < MAXC) begin
      e_tms[d][c]  = t;
      e_tdi[d][c]  = i;
      e_busy[d][c] = b;
      e_done[d][c] = dn;
      e_clr[d][c]  = cl;
    end
  endtask

  // Reference: a test accepted in cycle n shifts the pattern MSB first for
  // N cycles, spends one cycle capturing, N cycles shifting out, then one
  // done cycle. The inverting chain returns ~pattern.
  task automatic accept(int d, int n_len, logic [2:0] p, logic [2:0] e);
    int         n;
    sb_t        s;
    logic [2:0] mask;
    n    = cyc;
    mask = (n_len == 3) ? 3'b111 : 3'b001;
    for (int k = 0; k < n_len; k++)
      put(d, n + 1 + k, 1'b1, p[n_len-1-k], 1'b1, 1'b0, k == 0);
    put(d, n + n_len + 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < n_len; k++)
      put(d, n + n_len + 2 + k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    put(d, n + 2 * n_len + 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    s.cap  = ~p & mask;
    s.pass = (s.cap == (e & mask));
    s.cyc  = n + 2 * n_len + 2;
    if (d == 0) sb0.push_back(s);
    else        sb1.push_back(s);
    free_at[d]  = n + 2 * n_len + 3;
    last_acc[d] = n;
  endtask

  task automatic drive(bit s0, logic [2:0] p0, logic [2:0] e0, bit s1, logic p1, logic e1);
    @(negedge Clk);
    start0 = s0; pat0 = p0; exp0 = e0;
    start1 = s1; pat1 = p1; exp1 = e1;
    if (s0 && cyc >= free_at[0]) accept(0, 3, p0, e0);
    if (s1 && cyc >= free_at[1]) accept(1, 1, {2'b00, p1}, {2'b00, e1});
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mon(int d, logic t, logic i, logic b, logic dn, logic [2:0] cap, logic ps);
    int  c;
    sb_t s;
    c = cyc;
    if (c >= MAXC) return;
    chk($sformatf("dut%0d tms cyc%0d", d, c),  32'(t),  32'(e_tms[d][c]));
    chk($sformatf("dut%0d tdi cyc%0d", d, c),  32'(i),  32'(e_tdi[d][c]));
    chk($sformatf("dut%0d busy cyc%0d", d, c), 32'(b),  32'(e_busy[d][c]));
    chk($sformatf("dut%0d done cyc%0d", d, c), 32'(dn), 32'(e_done[d][c]));
    if (e_clr[d][c]) begin
      chk($sformatf("dut%0d captured cleared cyc%0d", d, c), 32'(cap), 32'(0));
      chk($sformatf("dut%0d pass cleared cyc%0d", d, c),     32'(ps),  32'(0));
    end
    if (dn) begin
      if (d == 0 && sb0.size() > 0)      s = sb0.pop_front();
      else if (d == 1 && sb1.size() > 0) s = sb1.pop_front();
      else begin
        n_vec++;
        n_mis++;
        $display("FAIL dut%0d done: unexpected pulse at cyc %0d, no pending test", d, c);
        return;
      end
      $display("dut%0d test done cyc %0d captured=%b pass=%b (want %b/%b)",
               d, c, cap, ps, s.cap, s.pass);
      chk($sformatf("dut%0d captured", d),  32'(cap), 32'(s.cap));
      chk($sformatf("dut%0d pass", d),      32'(ps),  32'(s.pass));
      chk($sformatf("dut%0d done cycle", d), 32'(c),  32'(s.cyc));
    end
  endtask

  always @(negedge Clk) begin
    if (ClrN) begin
      mon(0, tms0, tdi0, busy0, done0, cap0, pass0);
      mon(1, tms1, tdi1, busy1, done1, {2'b00, cap1}, pass1);
    end
  end

  task automatic check_zero(string tag);
    chk({tag, " tms0"},  32'(tms0),  32'(0));
    chk({tag, " tdi0"},  32'(tdi0),  32'(0));
    chk({tag, " busy0"}, 32'(busy0), 32'(0));
    chk({tag, " done0"}, 32'(done0), 32'(0));
    chk({tag, " pass0"}, 32'(pass0), 32'(0));
    chk({tag, " cap0"},  32'(cap0),  32'(0));
    chk({tag, " tms1"},  32'(tms1),  32'(0));
    chk({tag, " busy1"}, 32'(busy1), 32'(0));
    chk({tag, " done1"}, 32'(done1), 32'(0));
    chk({tag, " cap1"},  32'(cap1),  32'(0));
  endtask

  // Asserts ClrN mid-cycle, checks the outputs clear without a clock edge,
  // then releases it and forgets every pending expectation.
  task automatic do_reset();
    @(negedge Clk);
    #2 ClrN = 1'b0;
    #1 check_zero("async reset");
    @(negedge Clk);
    #2 ClrN = 1'b1;
    for (int d = 0; d < 2; d++) begin
      free_at[d] = cyc;
      for (int c = cyc - 1; c < MAXC; c++) put(d, c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    sb0.delete();
    sb1.delete();
  endtask

  logic [2:0] rp, re;
  logic       rp1, re1;
  int         n_acc;

  initial begin
    free_at[0] = 0;
    free_at[1] = 0;
    #1 ClrN = 1'b0;
    #1 check_zero("reset state");
    @(negedge Clk);
    #2 ClrN = 1'b1;
    idle(2);

    // Pattern 101, expect 010: passing test.
    drive(1'b1, 3'b101, 3'b010, 1'b0, 1'b0, 1'b0);
    idle(10);

    // Pattern 110, expect 000: failing test.
    drive(1'b1, 3'b110, 3'b000, 1'b0, 1'b0, 1'b0);
    idle(10);

    // start held high: back-to-back tests with one idle cycle between.
    repeat (30) begin
      rp = 3'($urandom);
      re = 3'($urandom);
      drive(1'b1, rp, re, 1'b0, 1'b0, 1'b0);
    end
    idle(10);

    // Reset in the second SHIFT_OUT cycle, then a fresh test.
    drive(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0);
    n_acc = last_acc[0];
    while (cyc < n_acc + 5) idle(1);
    do_reset();
    drive(1'b1, 3'b011, 3'b100, 1'b0, 1'b0, 1'b0);
    idle(10);

    // pattern_in changed right after acceptance.
    drive(1'b1, 3'b101, 3'b010, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    idle(10);

    // Single-flop build.
    drive(1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
    idle(6);

    // Random traffic on both builds.
    for (int k = 0; k < 300; k++) begin
      rp  = 3'($urandom);
      re  = ($urandom_range(0, 1) == 0) ? ~rp : 3'($urandom);
      rp1 = 1'($urandom);
      re1 = ($urandom_range(0, 1) == 0) ? ~rp1 : 1'($urandom);
      drive($urandom_range(0, 3) == 0, rp, re, $urandom_range(0, 2) == 0, rp1, re1);
    end

    // Bounded drain of outstanding tests.
    idle(30);
    n_vec++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d/%0d tests still pending, expected 0/0", sb0.size(), sb1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
